// File: rtl/store_queue.sv
// In-order store buffer between the AGU and the D-cache. Stores are held
// speculatively until the ROB commits them in order. Committed stores drain
// to the D-cache one at a time. Registered overlap/forwarding answers are
// given to the load pipe.
module store_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_i,
    input  logic        flush_i,
    input  logic        enq_vld_i,
    input  logic [5:0]  enq_rob_i,
    input  logic [29:0] enq_addr_i,
    input  logic [31:0] enq_data_i,
    input  logic [3:0]  enq_bm_i,
    output logic        sq_full_o,
    output logic        sq_empty_o,
    input  logic        commit_vld_i,
    input  logic [5:0]  commit_rob_i,
    output logic        commit_err_o,
    output logic        mem_req_vld_o,
    output logic [29:0] mem_req_addr_o,
    output logic [31:0] mem_req_data_o,
    output logic [3:0]  mem_req_bm_o,
    input  logic        mem_req_ack_i,
    input  logic        ld_chk_vld_i,
    input  logic [29:0] ld_chk_addr_i,
    input  logic [3:0]  ld_chk_bm_i,
    output logic        ld_hit_o,
    output logic        ld_fwd_vld_o,
    output logic [31:0] ld_fwd_data_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PtrW = IdxW + 1;

    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  bm_q   [DEPTH];
    logic [5:0]  rob_q  [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] cmt_q, cmt_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW-1:0] count;
    logic [IdxW-1:0] head_idx, cmt_idx, tail_idx;

    logic        err_q, err_d;
    logic        commit_ok;
    logic        enq_fire;

    logic        ld_hit_q, ld_hit_d;
    logic        ld_fwd_q, ld_fwd_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [3:0]  young_bm;
    logic [IdxW-1:0] q_idx;

    assign head_idx = head_q[IdxW-1:0];
    assign cmt_idx  = cmt_q[IdxW-1:0];
    assign tail_idx = tail_q[IdxW-1:0];

    assign count      = tail_q - head_q;
    assign sq_full_o  = (count == PtrW'(DEPTH));
    assign sq_empty_o = (count == '0);

    assign mem_req_vld_o  = (head_q != cmt_q);
    assign mem_req_addr_o = addr_q[head_idx];
    assign mem_req_data_o = data_q[head_idx];
    assign mem_req_bm_o   = bm_q[head_idx];

    assign commit_ok = (cmt_q != tail_q) && (rob_q[cmt_idx] == commit_rob_i);
    // A full queue stays full this cycle even if the head drains.
    assign enq_fire  = enq_vld_i & ~sq_full_o & ~flush_i;

    assign commit_err_o  = err_q;
    assign ld_hit_o      = ld_hit_q;
    assign ld_fwd_vld_o  = ld_fwd_q;
    assign ld_fwd_data_o = ld_data_q;

    // Pointer and error next-state: commit, then ack, then flush, then enqueue.
    always_comb begin
        head_d = head_q;
        cmt_d  = cmt_q;
        tail_d = tail_q;
        err_d  = err_q;
        if (commit_vld_i) begin
            if (commit_ok) begin
                cmt_d = cmt_q + PtrW'(1);
            end else begin
                err_d = 1'b1;
            end
        end
        if (mem_req_ack_i && mem_req_vld_o) begin
            head_d = head_q + PtrW'(1);
        end
        if (flush_i) begin
            // Flush keeps anything committed up to and including this cycle.
            tail_d = cmt_d;
        end else if (enq_fire) begin
            tail_d = tail_q + PtrW'(1);
        end
    end

    // Load query against the pre-update state; last match in age order wins.
    always_comb begin
        ld_hit_d  = 1'b0;
        ld_fwd_d  = 1'b0;
        ld_data_d = '0;
        young_bm  = '0;
        q_idx     = head_idx;
        if (ld_chk_vld_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                q_idx = head_idx + IdxW'(k);
                if ((PtrW'(k) < count) && (addr_q[q_idx] == ld_chk_addr_i) &&
                    (|(bm_q[q_idx] & ld_chk_bm_i))) begin
                    ld_hit_d  = 1'b1;
                    young_bm  = bm_q[q_idx];
                    ld_data_d = data_q[q_idx];
                end
            end
            ld_fwd_d = ld_hit_d && ((young_bm & ld_chk_bm_i) == ld_chk_bm_i);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            head_q    <= '0;
            cmt_q     <= '0;
            tail_q    <= '0;
            err_q     <= 1'b0;
            ld_hit_q  <= 1'b0;
            ld_fwd_q  <= 1'b0;
            ld_data_q <= '0;
        end else begin
            head_q    <= head_d;
            cmt_q     <= cmt_d;
            tail_q    <= tail_d;
            err_q     <= err_d;
            ld_hit_q  <= ld_hit_d;
            ld_fwd_q  <= ld_fwd_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Entry payload storage; contents are don't-care until written.
    always_ff @(posedge cpu_clock_i) begin
        if (enq_fire) begin
            addr_q[tail_idx] <= enq_addr_i;
            data_q[tail_idx] <= enq_data_i;
            bm_q[tail_idx]   <= enq_bm_i;
            rob_q[tail_idx]  <= enq_rob_i;
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: a vector table for the main flows, plus
// hand-written sequences for reset, empty-commit error and wrap throughput.
module tb_store_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        enq_vld;
    logic [5:0]  enq_rob;
    logic [29:0] enq_addr;
    logic [31:0] enq_data;
    logic [3:0]  enq_bm;
    logic        sq_full;
    logic        sq_empty;
    logic        commit_vld;
    logic [5:0]  commit_rob;
    logic        commit_err;
    logic        mem_vld;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_bm;
    logic        mem_ack;
    logic        ld_vld;
    logic [29:0] ld_addr;
    logic [3:0]  ld_bm;
    logic        ld_hit;
    logic        ld_fwd;
    logic [31:0] ld_data;

    always #5 clk = ~clk;

    store_queue #(.DEPTH(8)) dut (
        .cpu_clock_i    (clk),
        .cpu_reset_i    (rst),
        .flush_i        (flush),
        .enq_vld_i      (enq_vld),
        .enq_rob_i      (enq_rob),
        .enq_addr_i     (enq_addr),
        .enq_data_i     (enq_data),
        .enq_bm_i       (enq_bm),
        .sq_full_o      (sq_full),
        .sq_empty_o     (sq_empty),
        .commit_vld_i   (commit_vld),
        .commit_rob_i   (commit_rob),
        .commit_err_o   (commit_err),
        .mem_req_vld_o  (mem_vld),
        .mem_req_addr_o (mem_addr),
        .mem_req_data_o (mem_data),
        .mem_req_bm_o   (mem_bm),
        .mem_req_ack_i  (mem_ack),
        .ld_chk_vld_i   (ld_vld),
        .ld_chk_addr_i  (ld_addr),
        .ld_chk_bm_i    (ld_bm),
        .ld_hit_o       (ld_hit),
        .ld_fwd_vld_o   (ld_fwd),
        .ld_fwd_data_o  (ld_data)
    );

    typedef struct {
        logic        enq;
        logic [5:0]  rob;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  bm;
        logic        cmt;
        logic [5:0]  crob;
        logic        ack;
        logic        fl;
        logic        ld;
        logic [29:0] laddr;
        logic [3:0]  lbm;
        logic        x_full;
        logic        x_empty;
        logic        x_mvld;
        logic [29:0] x_maddr;
        logic        x_err;
        logic        x_hit;
        logic        x_fwd;
        logic [31:0] x_fdata;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic enq, input logic [5:0] rob, input logic [29:0] addr,
                       input logic [31:0] data, input logic [3:0] bm, input logic cmt,
                       input logic [5:0] crob, input logic ack, input logic fl,
                       input logic ld, input logic [29:0] laddr, input logic [3:0] lbm,
                       input logic x_full, input logic x_empty, input logic x_mvld,
                       input logic [29:0] x_maddr, input logic x_err, input logic x_hit,
                       input logic x_fwd, input logic [31:0] x_fdata);
        vec_t v;
        v.enq = enq; v.rob = rob; v.addr = addr; v.data = data; v.bm = bm;
        v.cmt = cmt; v.crob = crob; v.ack = ack; v.fl = fl;
        v.ld = ld; v.laddr = laddr; v.lbm = lbm;
        v.x_full = x_full; v.x_empty = x_empty; v.x_mvld = x_mvld; v.x_maddr = x_maddr;
        v.x_err = x_err; v.x_hit = x_hit; v.x_fwd = x_fwd; v.x_fdata = x_fdata;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        flush = 0; enq_vld = 0; enq_rob = '0; enq_addr = '0; enq_data = '0; enq_bm = '0;
        commit_vld = 0; commit_rob = '0; mem_ack = 0; ld_vld = 0; ld_addr = '0; ld_bm = '0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        chk({tag, " full"},  sq_full, 0);
        chk({tag, " empty"}, sq_empty, 1);
        chk({tag, " mvld"},  mem_vld, 0);
        chk({tag, " err"},   commit_err, 0);
        chk({tag, " hit"},   ld_hit, 0);
        chk({tag, " fwd"},   ld_fwd, 0);
        chk({tag, " fdata"}, ld_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [61:0] exp_q[$];
        logic [61:0] exp_e;
        int drained;

        rst = 1;
        idle_inputs();
        do_reset("reset");

        // Fill with 8 uncommitted stores; the ninth must be ignored.
        for (int i = 0; i < 8; i++)
            add(1, 6'(i), 30'h100 + 30'(i), 32'hD000_0000 + 32'(i), 4'hF, 0, 0, 0, 0,
                0, 0, 0, (i == 7), 0, 0, 0, 0, 0, 0, 0);
        add(1, 6'd63, 30'h1FF, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0,
            1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30'h1FF, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30'h103, 4'b0110,
            1, 0, 0, 0, 0, 1, 1, 32'hD000_0003);
        // Commit rob 0..2 with ack every cycle; first ack arrives before valid.
        add(0, 0, 0, 0, 0, 1, 6'd0, 1, 0, 0, 0, 0, 1, 0, 1, 30'h100, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 6'd1, 1, 0, 0, 0, 0, 0, 0, 1, 30'h101, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 6'd2, 1, 0, 0, 0, 0, 0, 0, 1, 30'h102, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Flush with commit of rob 3 and a suppressed enqueue.
        add(1, 6'd20, 30'h1AA, 32'h1, 4'hF, 1, 6'd3, 0, 1, 0, 0, 0,
            0, 0, 1, 30'h103, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 30'h105, 4'hF, 0, 1, 0, 0, 0, 0, 0, 0);
        // Forwarding: youngest full cover wins; partial cover hits but no forward.
        add(1, 6'd10, 30'h200, 32'h0000_AABB, 4'b0011, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 6'd11, 30'h200, 32'h1122_3344, 4'b1111, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30'h200, 4'b0001,
            0, 0, 0, 0, 0, 1, 1, 32'h1122_3344);
        add(1, 6'd12, 30'h300, 32'h00CC_0000, 4'b0100, 0, 0, 0, 0, 1, 30'h200, 4'b0011,
            0, 0, 0, 0, 0, 1, 1, 32'h1122_3344);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30'h300, 4'b1100,
            0, 0, 0, 0, 0, 1, 0, 32'h00CC_0000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h300, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0);
        // Tag mismatch sets sticky error; a correct commit still works after.
        add(0, 0, 0, 0, 0, 1, 6'd9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 6'd10, 0, 0, 0, 0, 0, 0, 0, 1, 30'h200, 1, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            flush = vq[i].fl; enq_vld = vq[i].enq; enq_rob = vq[i].rob;
            enq_addr = vq[i].addr; enq_data = vq[i].data; enq_bm = vq[i].bm;
            commit_vld = vq[i].cmt; commit_rob = vq[i].crob; mem_ack = vq[i].ack;
            ld_vld = vq[i].ld; ld_addr = vq[i].laddr; ld_bm = vq[i].lbm;
            @(posedge clk); #1;
            chk($sformatf("v%0d full", i),  sq_full, vq[i].x_full);
            chk($sformatf("v%0d empty", i), sq_empty, vq[i].x_empty);
            chk($sformatf("v%0d mvld", i),  mem_vld, vq[i].x_mvld);
            if (vq[i].x_mvld) chk($sformatf("v%0d maddr", i), mem_addr, vq[i].x_maddr);
            chk($sformatf("v%0d err", i),   commit_err, vq[i].x_err);
            chk($sformatf("v%0d hit", i),   ld_hit, vq[i].x_hit);
            chk($sformatf("v%0d fwd", i),   ld_fwd, vq[i].x_fwd);
            chk($sformatf("v%0d fdata", i), ld_data, vq[i].x_fdata);
        end

        // Reset with committed-but-undrained entries discards everything.
        do_reset("midreset");

        // Commit with nothing uncommitted is an error.
        commit_vld = 1; commit_rob = 6'd0;
        @(posedge clk); #1;
        commit_vld = 0;
        chk("empty commit err", commit_err, 1);
        chk("empty commit stays empty", sq_empty, 1);
        @(posedge clk); #1;
        chk("err sticky", commit_err, 1);
        do_reset("reset2");

        // Full-throughput enqueue/commit/drain; pointers wrap past 8 and 16.
        drained = 0;
        for (int c = 0; c < 24; c++) begin
            enq_vld = (c < 20); enq_rob = 6'(c); enq_bm = 4'hF;
            enq_addr = 30'h400 + 30'(c); enq_data = 32'hA500_0000 | 32'(c);
            commit_vld = (c >= 1 && c <= 20); commit_rob = 6'(c - 1);
            mem_ack = mem_vld;
            chk($sformatf("wrap c%0d not full", c), sq_full, 0);
            if (mem_vld) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL wrap c%0d: got request %0h, expected none", c, mem_addr);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk($sformatf("wrap drain %0d", drained), {mem_addr, mem_data}, exp_e);
                    drained++;
                end
            end
            if (enq_vld && !sq_full) exp_q.push_back({enq_addr, enq_data});
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("wrap drained count", drained, 20);
        chk("wrap final empty", sq_empty, 1);
        chk("wrap no err", commit_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/store_queue.md
# store_queue

In-order store buffer that sits directly downstream of the memory AGU. It accepts address-generated stores (word address, byte mask, aligned store data, ROB tag), holds them speculatively until the ROB commits them, then drains committed stores to the data cache one at a time. It also answers store-to-load overlap and forwarding queries from the load pipe.

## Interface
- DEPTH, 8, number of entries; power of two, minimum 2.
- cpu_clock_i  in  1  core clock; all state changes on the rising edge.
- cpu_reset_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush; discards all uncommitted entries.
- enq_vld_i  in  1  store from AGU is valid this cycle.
- enq_rob_i  in  6  ROB tag of the store.
- enq_addr_i  in  30  word address, i.e. byte address [31:2].
- enq_data_i  in  32  lane-aligned store data.
- enq_bm_i  in  4  byte mask, nonzero.
- sq_full_o  out  1  queue full; the AGU must hold the store while this is high.
- sq_empty_o  out  1  no valid entries.
- commit_vld_i  in  1  ROB commits the oldest uncommitted store.
- commit_rob_i  in  6  ROB tag being committed.
- commit_err_o  out  1  sticky: a commit arrived with no uncommitted entry, or with a tag mismatch.
- mem_req_vld_o  out  1  head entry is committed and offered to the D-cache.
- mem_req_addr_o  out  30  head word address.
- mem_req_data_o  out  32  head data.
- mem_req_bm_o  out  4  head byte mask.
- mem_req_ack_i  in  1  D-cache accepts the head entry.
- ld_chk_vld_i  in  1  load query valid.
- ld_chk_addr_i  in  30  load word address.
- ld_chk_bm_i  in  4  load byte mask.
- ld_hit_o  out  1  some valid entry overlaps the load.
- ld_fwd_vld_o  out  1  the youngest overlapping entry covers every load byte.
- ld_fwd_data_o  out  32  data of that youngest overlapping entry.

## Operation
- State:
  - Circular array of DEPTH entries: addr, data, bm, rob.
  - Three pointers, each log2(DEPTH)+1 bits with a wrap bit: head (oldest), cmt (oldest uncommitted), tail (next free).
  - Invariant: head ≤ cmt ≤ tail, modulo wrap.
- Count is tail−head.
  - sq_full_o = (count == DEPTH).
  - sq_empty_o = (count == 0).
  - Both are derived from the registered pointers only.
- Enqueue:
  - Condition: enq_vld_i & !sq_full_o & !flush_i.
  - Writes the entry at tail; tail += 1.
  - Enqueue while full is ignored; the AGU is required to hold.
  - A dequeue in the same cycle does not free space for that cycle's enqueue.
- Commit:
  - Condition: commit_vld_i with cmt ≠ tail and entry[cmt].rob == commit_rob_i; then cmt += 1.
  - Any other commit_vld_i sets commit_err_o, which holds until reset. The pointers do not move.
- Drain:
  - mem_req_vld_o = (head ≠ cmt).
  - mem_req_* reflect entry[head] combinationally.
  - mem_req_ack_i while mem_req_vld_o: head += 1.
  - Ack while not valid: ignored.
- Flush:
  - tail <= cmt after the commit update of the same cycle, so a store committed in the flush cycle survives.
  - Committed entries keep draining; drain is unaffected by flush.
- Forward query:
  - Per entry in [head, tail): match = (addr == ld_chk_addr_i) & |(bm & ld_chk_bm_i).
  - ld_hit_o = OR of match.
  - Youngest match is the one closest to tail, wrap-aware.
  - ld_fwd_vld_o = hit & ((youngest.bm & ld_chk_bm_i) == ld_chk_bm_i).
  - ld_fwd_data_o = youngest.data, or 0 when no hit.
  - Query state is sampled before any same-cycle enqueue, commit, drain or flush.
  - With ld_chk_vld_i low, all ld_* outputs are 0 on the next cycle.

## Timing
- Reset: head, cmt and tail = 0; commit_err_o = 0; ld_hit_o, ld_fwd_vld_o = 0; ld_fwd_data_o = 0.
  - Consequently sq_empty_o = 1, sq_full_o = 0, mem_req_vld_o = 0.
  - Entry contents are don't-care.
- Reset mid-operation discards everything, including committed-but-undrained entries. Reset overrides flush.
- Latency:
  - Enqueue at cycle N: the entry is visible to queries and commit at N+1.
  - Commit at N: mem_req_vld_o can rise at N+1.
  - Ack at N: the next head is presented at N+1.
- ld_* outputs are registered, one cycle after ld_chk_vld_i.
- sq_full_o and mem_req_vld_o depend only on registered state; there is no combinational path from inputs.
- Simultaneous enqueue, commit, ack and flush in one cycle are all legal. Resolution order: commit, ack, flush, then enqueue. Enqueue is suppressed by flush.
- Wrap: pointer MSB toggles at DEPTH; full versus empty is distinguished by the MSB.

## Test plan
- Reset, then enqueue 8 stores (addr 0x100+i, rob i) with no commit -> sq_full_o = 1 after the 8th; a 9th enq_vld_i is ignored; mem_req_vld_o = 0 throughout.
- Commit rob 0..2, ack every cycle -> mem_req_* show addr 0x100, 0x101, 0x102 in order on consecutive cycles; sq_empty_o stays 0 (5 left).
- With 3 committed and 5 uncommitted, flush in the same cycle as commit of rob 3 -> tail = cmt = 4; entries 0..3 drain, then sq_empty_o = 1.
- Stores bm 0011 data 0x0000_AABB then bm 1111 data 0x1122_3344 to the same addr, then load query bm 0001 -> next cycle ld_hit_o = 1, ld_fwd_vld_o = 1, data 0x1122_3344.
  - Repeat with only a bm 0100 store and load bm 1100 -> hit = 1, fwd = 0.
- Commit with rob 9 while the oldest uncommitted entry has rob 5 -> commit_err_o = 1 and stays high; cmt unchanged.
- 20 enqueue/commit/ack cycles at full throughput -> pointers wrap twice, no lost or reordered store, sq_full_o never asserts falsely.
